// File: rtl/sign_extend_pkg.sv
// Shared types, widths and the immediate-extension function for the ID-stage
// immediate unit.
package sign_extend_pkg;

  localparam int IN_W     = 12;
  localparam int OUT_W    = 21;
  localparam int NARROW_W = 8;

  typedef enum logic [1:0] {
    IMM_U12  = 2'b00,
    IMM_U8   = 2'b01,
    IMM_S12  = 2'b10,
    IMM_RSVD = 2'b11
  } imm_src_e;

  // Returns {err, value}; any encoding that is not a legal mode (including
  // unknowns in simulation) falls to the default and is reported as an error.
  function automatic logic [OUT_W:0] extend_imm(input logic [IN_W-1:0] num,
                                                input logic [1:0]      src);
    logic [OUT_W:0] res;
    res = '0;
    case (src)
      IMM_U12: res = {1'b0, {(OUT_W-IN_W){1'b0}}, num};
      IMM_U8:  res = {1'b0, {(OUT_W-NARROW_W){1'b0}}, num[NARROW_W-1:0]};
      IMM_S12: res = {1'b0, {(OUT_W-IN_W){num[IN_W-1]}}, num};
      default: res = {1'b1, {OUT_W{1'b0}}};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sign_extend_core.sv
// Combinational extension-mode mux; the top registers its result.
module sign_extend_core
  import sign_extend_pkg::*;
(
  input  logic [IN_W-1:0]  num_i,
  input  logic [1:0]       imm_src_i,
  output logic [OUT_W-1:0] num_o,
  output logic             err_o
);

  logic [OUT_W:0] ext;

  assign ext   = extend_imm(num_i, imm_src_i);
  assign num_o = ext[OUT_W-1:0];
  assign err_o = ext[OUT_W];

endmodule

// File: rtl/sign_extend.sv
// Registered immediate-extension unit: one result per accepted input, one
// cycle of latency, data/err hold while no new input arrives.
module sign_extend
  import sign_extend_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  num_in,
  input  logic [1:0]       imm_src,
  output logic             out_valid,
  output logic [OUT_W-1:0] num_out,
  output logic             err
);

  logic [OUT_W-1:0] ext_num;
  logic             ext_err;

  logic             valid_q, valid_d;
  logic [OUT_W-1:0] num_q, num_d;
  logic             err_q, err_d;

  sign_extend_core u_core (
    .num_i     (num_in),
    .imm_src_i (imm_src),
    .num_o     (ext_num),
    .err_o     (ext_err)
  );

  always_comb begin
    valid_d = in_valid;
    num_d   = num_q;
    err_d   = err_q;
    if (in_valid) begin
      num_d = ext_num;
      err_d = ext_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign num_out   = num_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sign_extend.sv
// Directed-vector bench for sign_extend with hand-computed expectations.
module tb_sign_extend;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] num_in;
  logic [1:0]  imm_src;
  logic        out_valid;
  logic [20:0] num_out;
  logic        err;

  int checks;
  int failures;

  sign_extend dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .num_in    (num_in),
    .imm_src   (imm_src),
    .out_valid (out_valid),
    .num_out   (num_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one input at the falling edge, then check the registered result
  // just after the next rising edge.
  task automatic step(input string tag, input logic v, input logic [11:0] n,
                      input logic [1:0] s, input logic exp_v,
                      input logic [20:0] exp_num, input logic exp_err);
    @(negedge clk);
    in_valid = v;
    num_in   = n;
    imm_src  = s;
    @(posedge clk);
    #1;
    check_eq({tag, "_valid"}, {31'b0, out_valid}, {31'b0, exp_v});
    check_eq({tag, "_num"},   {11'b0, num_out},   {11'b0, exp_num});
    check_eq({tag, "_err"},   {31'b0, err},       {31'b0, exp_err});
    $display("txn %-10s v=%0b num_in=%03h src=%0d -> out_valid=%0b num_out=%06h err=%0b",
             tag, v, n, s, out_valid, num_out, err);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    num_in   = '0;
    imm_src  = '0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst0_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst0_num",   {11'b0, num_out},   32'd0);
    check_eq("rst0_err",   {31'b0, err},       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back accepted inputs with alternating modes.
    step("u12_0f0",  1'b1, 12'h0F0, 2'b00, 1'b1, 21'h0000F0, 1'b0);
    step("u8_00f",   1'b1, 12'h00F, 2'b01, 1'b1, 21'h00000F, 1'b0);
    step("u8_abc",   1'b1, 12'hABC, 2'b01, 1'b1, 21'h0000BC, 1'b0);
    step("s12_f0f",  1'b1, 12'hF0F, 2'b10, 1'b1, 21'h1FFF0F, 1'b0);
    step("s12_08f",  1'b1, 12'h08F, 2'b10, 1'b1, 21'h00008F, 1'b0);
    step("rsvd_5a5", 1'b1, 12'h5A5, 2'b11, 1'b1, 21'h000000, 1'b1);
    step("u12_fff",  1'b1, 12'hFFF, 2'b00, 1'b1, 21'h000FFF, 1'b0);
    step("s12_800",  1'b1, 12'h800, 2'b10, 1'b1, 21'h1FF800, 1'b0);
    step("u8_fff",   1'b1, 12'hFFF, 2'b01, 1'b1, 21'h0000FF, 1'b0);
    step("s12_7ff",  1'b1, 12'h7FF, 2'b10, 1'b1, 21'h0007FF, 1'b0);

    // Idle cycles: valid drops, data and err hold.
    step("idle_a",   1'b0, 12'h123, 2'b00, 1'b0, 21'h0007FF, 1'b0);
    step("rsvd_fff", 1'b1, 12'hFFF, 2'b11, 1'b1, 21'h000000, 1'b1);
    step("idle_b",   1'b0, 12'hF00, 2'b10, 1'b0, 21'h000000, 1'b1);
    step("u12_0aa",  1'b1, 12'h0AA, 2'b00, 1'b1, 21'h0000AA, 1'b0);

    // Mid-cycle asynchronous reset clears outputs without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst1_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst1_num",   {11'b0, num_out},   32'd0);
    check_eq("rst1_err",   {31'b0, err},       32'd0);

    // An input presented while reset is held is dropped.
    step("in_rst",   1'b1, 12'hF0F, 2'b10, 1'b0, 21'h000000, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step("post_rst", 1'b1, 12'h801, 2'b10, 1'b1, 21'h1FF801, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
